// File: rtl/trv_lsu_pkg.sv
// Shared definitions for the TRV-32I load/store unit data-memory port:
// FSM state encodings, RV32I load/store funct3 codes and lane count.
package trv_lsu_pkg;

    // Number of byte lanes on the 32-bit data-memory bus.
    localparam int BE_W = 4;

    // FSM state encoding (plain constants, kept legacy-compatible).
    typedef logic [2:0] lsu_state_t;
    localparam lsu_state_t S_IDLE    = 3'd0;
    localparam lsu_state_t S_RD_ADDR = 3'd1;
    localparam lsu_state_t S_RD_DATA = 3'd2;
    localparam lsu_state_t S_WR      = 3'd3;
    localparam lsu_state_t S_RESP    = 3'd4;

    // RV32I load/store funct3 codes. Bits [1:0] give the access size
    // (00 byte, 01 half, 10 word); bit 2 selects zero-extension on loads.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath helpers for the LSU memory port: byte-enable
// generation, store-data lane replication, load-data extraction with
// sign/zero extension, and the illegal/misaligned access check.
module lsu_align
    import trv_lsu_pkg::*;
#(
    parameter int B_WIDTH = 32
) (
    input  logic                   we,
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    input  logic [B_WIDTH-1:0]     wdata,
    input  logic [B_WIDTH-1:0]     rdata,
    output logic [B_WIDTH/8-1:0]   byte_en,
    output logic [B_WIDTH-1:0]     wdata_lane,
    output logic [B_WIDTH-1:0]     rdata_ext,
    output logic                   err
);

    logic [B_WIDTH-1:0] rdata_shift;
    logic               f3_legal;
    logic               misaligned;

    // Byte enables and store-data replication by access size. Replicating
    // the data into every lane lets the byte enables alone pick the target.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        byte_en    = '0;
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            2'b10: begin
                byte_en    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign rdata_shift = rdata >> {addr_lo, 3'b000};

    // Load extraction: signed forms replicate the top bit of the lane.
    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rdata_shift[7]}},  rdata_shift[7:0]};
            F3_H:    rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            F3_W:    rdata_ext = rdata_shift;
            F3_BU:   rdata_ext = {24'h0, rdata_shift[7:0]};
            F3_HU:   rdata_ext = {16'h0, rdata_shift[15:0]};
            default: rdata_ext = '0;
        endcase
    end

    // Stores only have signed-size encodings; loads add the unsigned ones.
    assign f3_legal = we ? (funct3 inside {F3_B, F3_H, F3_W})
                         : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    // Halfwords must sit on an even address, words on a multiple of four.
    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

    assign err = !f3_legal || misaligned;

endmodule

// File: rtl/lsu_mem_port.sv
// Initiator side of the TRV-32I data-memory interface. Takes one load or
// store at a time, runs a short fixed sequence on the memory bus and returns
// a single-cycle response. Illegal or misaligned requests skip the bus and
// respond with an error on the following cycle.
module lsu_mem_port
    import trv_lsu_pkg::*;
#(
    parameter int B_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [B_WIDTH-1:0]     req_addr,
    input  logic [B_WIDTH-1:0]     req_wdata,
    output logic                   resp_valid,
    output logic [B_WIDTH-1:0]     resp_data,
    output logic                   resp_err,
    output logic [B_WIDTH-1:0]     mem_addr,
    output logic                   mem_read_en,
    output logic                   mem_write_en,
    output logic [B_WIDTH/8-1:0]   write_byte_en,
    output logic [B_WIDTH-1:0]     mem_wdata,
    input  logic [B_WIDTH-1:0]     mem_rdata
);

    lsu_state_t state_q;
    lsu_state_t state_d;

    // Request fields latched at acceptance.
    logic                 we_q;
    logic [2:0]           f3_q;
    logic [1:0]           addr_lo_q;
    logic                 err_q;
    logic [B_WIDTH-1:0]   mem_addr_q;
    logic [B_WIDTH-1:0]   mem_wdata_q;
    logic [B_WIDTH-1:0]   rdata_q;

    logic                 is_idle;
    logic                 accept;

    // The single alignment unit sees the live request while idle (to check
    // and steer it at acceptance) and the latched request otherwise (to drive
    // byte enables in WR and extract load data in RESP).
    logic                 al_we;
    logic [2:0]           al_f3;
    logic [1:0]           al_addr_lo;
    logic [BE_W-1:0]      al_byte_en;
    logic [B_WIDTH-1:0]   al_wdata_lane;
    logic [B_WIDTH-1:0]   al_rdata_ext;
    logic                 al_err;

    assign is_idle    = (state_q == S_IDLE);
    assign accept     = req_valid && is_idle;

    assign al_we      = is_idle ? req_we         : we_q;
    assign al_f3      = is_idle ? req_funct3     : f3_q;
    assign al_addr_lo = is_idle ? req_addr[1:0]  : addr_lo_q;

    lsu_align #(
        .B_WIDTH    (B_WIDTH)
    ) u_align (
        .we         (al_we),
        .funct3     (al_f3),
        .addr_lo    (al_addr_lo),
        .wdata      (req_wdata),
        .rdata      (rdata_q),
        .byte_en    (al_byte_en),
        .wdata_lane (al_wdata_lane),
        .rdata_ext  (al_rdata_ext),
        .err        (al_err)
    );

    // Next-state logic: loads take two bus cycles, stores one, errors none.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (al_err)      state_d = S_RESP;
                    else if (req_we) state_d = S_WR;
                    else             state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: state_d = S_RD_DATA;
            S_RD_DATA: state_d = S_RESP;
            S_WR:      state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; an in-flight access is simply dropped
    // on reset, so no response is ever produced for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset as well, so the bus outputs
            // read as zero from the first cycle instead of as X.
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_lo_q   <= 2'b00;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q <= state_d;
            if (accept) begin
                we_q        <= req_we;
                f3_q        <= req_funct3;
                addr_lo_q   <= req_addr[1:0];
                err_q       <= al_err;
                mem_addr_q  <= {2'b00, req_addr[B_WIDTH-1:2]};
                mem_wdata_q <= al_wdata_lane;
            end
            if (state_q == S_RD_DATA) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Output decode. Strobes are state-exclusive, so read and write can
    // never be asserted together.
    assign req_ready     = is_idle;
    assign resp_valid    = (state_q == S_RESP);
    assign resp_err      = resp_valid && err_q;
    assign resp_data     = (resp_valid && !we_q && !err_q) ? al_rdata_ext : '0;
    assign mem_read_en   = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
    assign mem_write_en  = (state_q == S_WR);
    assign write_byte_en = mem_write_en ? al_byte_en : '0;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit port for the TRV-32I core: the initiator side of the data-memory interface. Accepts one RV32I load or store request at a time from the execute stage and sequences word-indexed, byte-enabled accesses on the data-memory bus. Steers store data into byte lanes and extracts and sign- or zero-extends load data. Flags misaligned or illegal-funct3 accesses as errors without touching memory.

## Interface
- B_WIDTH, 32: data/address width; only 32 supported
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (size/sign)
- req_addr  in  B_WIDTH  byte address
- req_wdata  in  B_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  B_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
- mem_addr  out  B_WIDTH  word index = {2'b00, addr[31:2]}
- mem_read_en  out  1  read strobe
- mem_write_en  out  1  write strobe
- write_byte_en  out  B_WIDTH/8  byte-lane enables
- mem_wdata  out  B_WIDTH  lane-steered store data; integration drives shared bus with it only while mem_write_en=1
- mem_rdata  in  B_WIDTH  shared bus, sampled in RD_DATA

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- IDLE: on req_valid && req_ready, latch we/funct3/addr/wdata; go to RD_ADDR (load) or WR (store). On error, go directly to RESP with err=1.
- Error: load funct3 ∉ {000,001,010,100,101}; store funct3 ∉ {000,001,010}; halfword with addr[0]=1; word with addr[1:0]≠0.
- RD_ADDR: mem_read_en=1, mem_addr driven; → RD_DATA.
- RD_DATA: mem_read_en=1, same mem_addr; capture mem_rdata into an internal register at posedge; → RESP.
- WR: mem_write_en=1, write_byte_en and mem_wdata driven; → RESP.
- RESP: resp_valid=1 for exactly one cycle; → IDLE.
- mem_read_en and mem_write_en are never high together.
- Byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0] (addr[1]∈{0,1}); SW 1111. Store data replicated: byte into all lanes, half into both halves.
- Load extract: lane = rdata >> (8*addr[1:0]); LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW pass-through.
- Outside the listed states, mem_* strobes and write_byte_en = 0; mem_addr and mem_wdata hold their latched values.

## Timing
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_data=0; mem_read_en=0, mem_write_en=0, write_byte_en=0; mem_addr=0, mem_wdata=0.
- Load: accept at cycle 0, strobes in cycles 1–2, resp_valid in cycle 3.
- Store: accept at cycle 0, write in cycle 1, resp_valid in cycle 2.
- Error: accept at cycle 0, resp_valid with resp_err in cycle 1, no memory strobes.
- Back-to-back: the next request is accepted in the cycle after RESP (IDLE). req_valid during busy states is ignored, not queued.
- Reset mid-operation: return to IDLE next cycle with all strobes low. The in-flight access is dropped and no resp_valid is produced.

## Structure
- Package trv_lsu_pkg: state enum, funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), byte-enable width constant.
- Sub-module lsu_align (combinational): byte-enable generation, store-lane steering, load extraction/extension, alignment check. The FSM and registers stay in lsu_mem_port.

## Test plan
- Reset, then SW addr=0x10, wdata=0xDEADBEEF → cycle 1: mem_addr=0x4, byte_en=1111, mem_wdata=0xDEADBEEF; cycle 2: resp_valid=1, err=0.
- SB addr=0x13, wdata=0xA5 → byte_en=1000, mem_wdata=0xA5A5A5A5. Then LB addr=0x13 with mem_rdata=0xA5000000 → resp_data=0xFFFFFFA5; LBU → 0x000000A5.
- LH addr=0x12, mem_rdata=0x80010000 → resp_data=0xFFFF8001; LHU → 0x00008001; read_en high exactly cycles 1–2.
- LW addr=0x6, and SH addr=0x3 → resp_err=1 in cycle 1, no strobes, resp_data=0; load funct3=011 → resp_err=1.
- Assert rst during RD_DATA → next cycle IDLE, req_ready=1, strobes low, no resp_valid.
- req_valid held high through a load → req_ready low in cycles 1–3, second request accepted in cycle 4.
